// File: rtl/comp_race_sequencer.sv
// Race-logic comparison sequencer: clears external edge latches, then times the
// first synchronised rising edges of x_pulse/y_pulse within a window and reports them.
module comp_race_sequencer #(
   parameter int unsigned CW          = 8,
   parameter int unsigned WINDOW      = 255,
   parameter int unsigned CLR_CYC     = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          start_valid,
   output logic          start_ready,
   input  logic          x_pulse,
   input  logic          y_pulse,
   output logic          edge_clr_b,
   output logic          busy,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [1:0]    res_winner,
   output logic [CW-1:0] res_x_time,
   output logic [CW-1:0] res_y_time
);

   localparam int unsigned ClrW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

   typedef enum logic [1:0] {StIdle, StClear, StRace, StDone} state_e;

   state_e                 state_q, state_d;
   logic [CW-1:0]          t_q, t_d;
   logic [ClrW-1:0]        clr_q, clr_d;
   logic                   x_seen_q, x_seen_d, y_seen_q, y_seen_d;
   logic [CW-1:0]          x_time_q, x_time_d, y_time_q, y_time_d;
   logic [1:0]             res_winner_q, res_winner_d;
   logic [CW-1:0]          res_x_time_q, res_x_time_d, res_y_time_q, res_y_time_d;
   logic [SYNC_STAGES-1:0] x_sync_q, y_sync_q;
   logic                   xd_q, yd_q;
   logic                   start_ready_q, edge_clr_b_q;
   logic                   xs, ys, x_edge, y_edge;

   assign xs     = x_sync_q[SYNC_STAGES-1];
   assign ys     = y_sync_q[SYNC_STAGES-1];
   assign x_edge = xs & ~xd_q;
   assign y_edge = ys & ~yd_q;

   function automatic logic [1:0] resolve(input logic xv, input logic yv,
                                          input logic [CW-1:0] xt, input logic [CW-1:0] yt);
      if (xv && yv) begin
         if (xt < yt)      return 2'b01;
         else if (yt < xt) return 2'b10;
         else              return 2'b11;
      end
      return {yv, xv};
   endfunction

   always_comb begin
      state_d      = state_q;
      t_d          = t_q;
      clr_d        = clr_q;
      x_seen_d     = x_seen_q;
      y_seen_d     = y_seen_q;
      x_time_d     = x_time_q;
      y_time_d     = y_time_q;
      res_winner_d = res_winner_q;
      res_x_time_d = res_x_time_q;
      res_y_time_d = res_y_time_q;
      unique case (state_q)
         StIdle: begin
            if (start_valid) begin
               state_d  = StClear;
               clr_d    = '0;
               x_seen_d = 1'b0;
               y_seen_d = 1'b0;
               x_time_d = '1;
               y_time_d = '1;
            end
         end
         StClear: begin
            if (clr_q == ClrW'(CLR_CYC - 1)) begin
               state_d = StRace;
               t_d     = '0;
            end else begin
               clr_d = clr_q + 1'b1;
            end
         end
         StRace: begin
            if (x_edge && !x_seen_q) begin
               x_seen_d = 1'b1;
               x_time_d = t_q;
            end
            if (y_edge && !y_seen_q) begin
               y_seen_d = 1'b1;
               y_time_d = t_q;
            end
            // Edges in the final window cycle still count, so exit is judged on next-state flags.
            if ((x_seen_d && y_seen_d) || (t_q == CW'(WINDOW - 1))) begin
               state_d      = StDone;
               res_winner_d = resolve(x_seen_d, y_seen_d, x_time_d, y_time_d);
               res_x_time_d = x_time_d;
               res_y_time_d = y_time_d;
            end else begin
               t_d = t_q + 1'b1;
            end
         end
         StDone: begin
            if (res_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q       <= StIdle;
         t_q           <= '0;
         clr_q         <= '0;
         x_seen_q      <= 1'b0;
         y_seen_q      <= 1'b0;
         x_time_q      <= '1;
         y_time_q      <= '1;
         res_winner_q  <= 2'b00;
         res_x_time_q  <= '1;
         res_y_time_q  <= '1;
         x_sync_q      <= '0;
         y_sync_q      <= '0;
         xd_q          <= 1'b0;
         yd_q          <= 1'b0;
         start_ready_q <= 1'b0;
         edge_clr_b_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         t_q           <= t_d;
         clr_q         <= clr_d;
         x_seen_q      <= x_seen_d;
         y_seen_q      <= y_seen_d;
         x_time_q      <= x_time_d;
         y_time_q      <= y_time_d;
         res_winner_q  <= res_winner_d;
         res_x_time_q  <= res_x_time_d;
         res_y_time_q  <= res_y_time_d;
         x_sync_q      <= {x_sync_q[SYNC_STAGES-2:0], x_pulse};
         y_sync_q      <= {y_sync_q[SYNC_STAGES-2:0], y_pulse};
         xd_q          <= xs;
         yd_q          <= ys;
         // Registered handshake/clear outputs track the state being entered.
         start_ready_q <= (state_d == StIdle);
         edge_clr_b_q  <= (state_d != StClear);
      end
   end

   assign start_ready = start_ready_q;
   assign edge_clr_b  = edge_clr_b_q;
   assign busy        = (state_q != StIdle);
   assign res_valid   = (state_q == StDone);
   assign res_winner  = res_winner_q;
   assign res_x_time  = res_x_time_q;
   assign res_y_time  = res_y_time_q;

endmodule
